// File: rtl/icache_pkg.sv
// Shared cache definitions: controller states and address-field width helpers.
// Also used by the d-cache, so keep it free of i-cache specifics.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MEM_READ,
        CACHE_WRITE,
        FLUSH
    } state_t;

    function automatic int off_w(input int words);
        return $clog2(words) + 2;
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int sets, input int words);
        return addr_w - idx_w(sets) - off_w(words);
    endfunction

    // A direct-mapped cache still needs a 1-bit way index to keep widths legal
    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/icache_assoc_if.sv
// Fetch-side and block-memory-side signals of the set-associative i-cache.
// The master is the CPU/memory environment; the slave is the cache itself.
interface icache_assoc_if #(
    parameter int ADDR_W = 32,
    parameter int WORDS  = 4
);
    import icache_pkg::*;

    localparam int OFF_W = off_w(WORDS);

    logic [ADDR_W-1:0]         address;
    logic                      read;
    logic                      flush;
    logic [31:0]               instruction;
    logic                      busywait;
    logic                      mem_read;
    logic [ADDR_W-OFF_W+1:0]   mem_address;
    logic [32*WORDS-1:0]       mem_readdata;
    logic                      mem_busywait;

    modport master (
        output address, read, flush, mem_readdata, mem_busywait,
        input  instruction, busywait, mem_read, mem_address
    );

    modport slave (
        input  address, read, flush, mem_readdata, mem_busywait,
        output instruction, busywait, mem_read, mem_address
    );

endinterface

// File: rtl/icache_lru.sv
// Per-set LRU age tracking: age 0 is most recent, age WAYS-1 is the eviction candidate.
// Invalid ways are preferred as victims, lowest index first.
module icache_lru
    import icache_pkg::*;
#(
    parameter int SETS = 8,
    parameter int WAYS = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [idx_w(SETS)-1:0]    set_idx,
    input  logic                      touch,
    input  logic [way_w(WAYS)-1:0]    touch_way,
    input  logic                      clear,
    input  logic [WAYS-1:0]           set_valid,
    output logic [way_w(WAYS)-1:0]    victim
);
    localparam int WAY_W = way_w(WAYS);

    logic [WAY_W-1:0] ages [SETS][WAYS];

    always_comb begin
        victim = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (ages[set_idx][w] == WAY_W'(WAYS - 1)) begin
                victim = WAY_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!set_valid[w]) begin
                victim = WAY_W'(w);
            end
        end
    end

    // Touched way becomes age 0; only younger ways age, so ages stay a permutation
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    ages[s][w] <= WAY_W'(w);
                end
            end
        end else if (clear) begin
            for (int w = 0; w < WAYS; w++) begin
                ages[set_idx][w] <= WAY_W'(w);
            end
        end else if (touch) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == touch_way) begin
                    ages[set_idx][w] <= '0;
                end else if (ages[set_idx][w] < ages[set_idx][touch_way]) begin
                    ages[set_idx][w] <= ages[set_idx][w] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache: combinational hits, one-block refill on a miss,
// and a set-by-set full invalidate triggered by a flush pulse.
module icache_assoc
    import icache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int SETS   = 8,
    parameter int WAYS   = 2,
    parameter int WORDS  = 4
) (
    input  logic           clock,
    input  logic           reset,
    icache_assoc_if.slave  bus
);
    localparam int OFF_W  = off_w(WORDS);
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_W, SETS, WORDS);
    localparam int WAY_W  = way_w(WAYS);
    localparam int WOFF_W = OFF_W - 2;
    localparam int BLK_W  = ADDR_W - OFF_W;

    state_t                     state;
    logic                       flush_pending;
    logic [IDX_W-1:0]           flush_idx;
    logic [BLK_W-1:0]           miss_block;
    logic [32*WORDS-1:0]        fill_data;
    logic [SETS-1:0][WAYS-1:0]  valid;
    logic [TAG_W-1:0]           tags   [SETS][WAYS];
    logic [32*WORDS-1:0]        blocks [SETS][WAYS];

    logic [TAG_W-1:0]   addr_tag;
    logic [IDX_W-1:0]   addr_idx;
    logic [WOFF_W-1:0]  addr_off;
    logic [TAG_W-1:0]   miss_tag;
    logic [IDX_W-1:0]   miss_idx;
    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    logic [IDX_W-1:0]   lru_idx;
    logic               touch;
    logic [WAY_W-1:0]   touch_way;
    logic [WAY_W-1:0]   victim;

    assign addr_tag = bus.address[ADDR_W-1:IDX_W+OFF_W];
    assign addr_idx = bus.address[IDX_W+OFF_W-1:OFF_W];
    assign addr_off = bus.address[OFF_W-1:2];
    assign miss_tag = miss_block[BLK_W-1:IDX_W];
    assign miss_idx = miss_block[IDX_W-1:0];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[addr_idx][w] && tags[addr_idx][w] == addr_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        bus.instruction = hit ? blocks[addr_idx][hit_way][32*addr_off +: 32] : 32'h0;
    end

    // A miss must stall in the very cycle it is presented; reset forces the stall low
    assign bus.busywait = !reset && ((state != IDLE) || (bus.read && !hit));

    always_comb begin
        lru_idx   = addr_idx;
        touch     = 1'b0;
        touch_way = hit_way;
        unique case (state)
            IDLE:        touch = bus.read && hit;
            MEM_READ:    lru_idx = miss_idx;
            CACHE_WRITE: begin
                lru_idx   = miss_idx;
                touch     = 1'b1;
                touch_way = victim;
            end
            FLUSH:       lru_idx = flush_idx;
            default:     lru_idx = addr_idx;
        endcase
    end

    icache_lru #(
        .SETS (SETS),
        .WAYS (WAYS)
    ) u_lru (
        .clock     (clock),
        .reset     (reset),
        .set_idx   (lru_idx),
        .touch     (touch),
        .touch_way (touch_way),
        .clear     (state == FLUSH),
        .set_valid (valid[lru_idx]),
        .victim    (victim)
    );

    // A flush seen mid-fill is remembered so the fill finishes before invalidation
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            flush_pending   <= 1'b0;
            flush_idx       <= '0;
            miss_block      <= '0;
            fill_data       <= '0;
            valid           <= '0;
            bus.mem_read    <= 1'b0;
            bus.mem_address <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (flush_pending || bus.flush) begin
                        flush_idx <= '0;
                        state     <= FLUSH;
                    end else if (bus.read && !hit) begin
                        miss_block      <= bus.address[ADDR_W-1:OFF_W];
                        bus.mem_address <= {2'b00, bus.address[ADDR_W-1:OFF_W]};
                        bus.mem_read    <= 1'b1;
                        state           <= MEM_READ;
                    end
                end
                MEM_READ: begin
                    if (bus.flush) flush_pending <= 1'b1;
                    if (!bus.mem_busywait) begin
                        fill_data    <= bus.mem_readdata;
                        bus.mem_read <= 1'b0;
                        state        <= CACHE_WRITE;
                    end
                end
                CACHE_WRITE: begin
                    if (bus.flush) flush_pending <= 1'b1;
                    valid[miss_idx][victim] <= 1'b1;
                    state                   <= IDLE;
                end
                FLUSH: begin
                    valid[flush_idx] <= '0;
                    if (bus.flush) begin
                        flush_pending <= 1'b1;
                        flush_idx     <= '0;
                    end else if (flush_idx == IDX_W'(SETS - 1)) begin
                        flush_pending <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        flush_idx <= flush_idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (state == CACHE_WRITE) begin
            tags[miss_idx][victim]   <= miss_tag;
            blocks[miss_idx][victim] <= fill_data;
        end
    end

endmodule

// File: tb/tb_icache_assoc.sv
// Bench for icache_assoc: directed scenarios then random fetches checked against
// a recency-list model of each set and a formula-defined instruction memory.
module tb_icache_assoc;
    import icache_pkg::*;

    localparam int ADDR_W = 32;
    localparam int SETS   = 8;
    localparam int WAYS   = 2;
    localparam int WORDS  = 4;
    localparam int OFF_W  = off_w(WORDS);

    logic clock = 1'b0;
    logic reset;
    int   tests    = 0;
    int   failures = 0;
    int   mem_lat  = 5;
    int   mem_cnt;

    icache_assoc_if #(.ADDR_W(ADDR_W), .WORDS(WORDS)) bus ();

    icache_assoc #(
        .ADDR_W (ADDR_W),
        .SETS   (SETS),
        .WAYS   (WAYS),
        .WORDS  (WORDS)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] word_addr);
        return word_addr * 32'h9E37_79B1 + 32'h1357_2468;
    endfunction

    // Memory answers in the mem_lat-th cycle that mem_read is seen high
    always @(posedge clock or posedge reset) begin
        if (reset || !bus.mem_read) mem_cnt <= 0;
        else                        mem_cnt <= mem_cnt + 1;
    end

    always_comb begin
        bus.mem_busywait = !(bus.mem_read && (mem_cnt >= mem_lat - 1));
        for (int k = 0; k < WORDS; k++) begin
            bus.mem_readdata[32*k +: 32] =
                mem_word((32'(bus.mem_address) << (OFF_W - 2)) + 32'(k));
        end
    end

    // Each set is a list of block numbers, most recently used first
    int unsigned model_sets [SETS][$];

    function automatic bit model_access(input logic [31:0] addr);
        int unsigned blk = addr >> OFF_W;
        int s = int'(blk % SETS);
        for (int i = 0; i < model_sets[s].size(); i++) begin
            if (model_sets[s][i] == blk) begin
                model_sets[s].delete(i);
                model_sets[s].push_front(blk);
                return 1'b1;
            end
        end
        if (model_sets[s].size() == WAYS) void'(model_sets[s].pop_back());
        model_sets[s].push_front(blk);
        return 1'b0;
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < SETS; s++) model_sets[s].delete();
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        tests++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr);
        bit exp_hit;
        int busy;
        int rd_cycles;
        bit addr_seen;
        exp_hit = model_access(addr);
        @(posedge clock); #1;
        bus.address = addr;
        bus.read    = 1'b1;
        @(negedge clock);
        checkOutput("busywait_now", bus.busywait, !exp_hit);
        if (!exp_hit) begin
            busy      = 0;
            rd_cycles = 0;
            addr_seen = 1'b0;
            while (bus.busywait && busy < 200) begin
                busy++;
                if (bus.mem_read) begin
                    rd_cycles++;
                    if (!addr_seen) begin
                        addr_seen = 1'b1;
                        checkOutput("mem_address", bus.mem_address, addr >> OFF_W);
                    end
                end
                @(negedge clock);
            end
            checkOutput("miss_latency", busy, mem_lat + 2);
            checkOutput("mem_read_cycles", rd_cycles, mem_lat);
        end
        checkOutput("mem_read_low", bus.mem_read, 1'b0);
        checkOutput("instruction", bus.instruction, mem_word(addr >> 2));
    endtask

    task automatic countFlush();
        int n = 0;
        @(negedge clock);
        while (bus.busywait && n < 100) begin
            n++;
            @(negedge clock);
        end
        checkOutput("flush_cycles", n, SETS);
        model_clear();
    endtask

    task automatic flushCache();
        @(posedge clock); #1;
        bus.read  = 1'b0;
        bus.flush = 1'b1;
        @(negedge clock);
        checkOutput("flush_pulse_busy", bus.busywait, 1'b0);
        @(posedge clock); #1;
        bus.flush = 1'b0;
        countFlush();
    endtask

    task automatic idleCycle();
        @(posedge clock); #1;
        bus.read = 1'b0;
        @(negedge clock);
        checkOutput("idle_busy", bus.busywait, 1'b0);
    endtask

    initial begin
        int n;
        logic [31:0] a;
        reset       = 1'b1;
        bus.address = '0;
        bus.read    = 1'b0;
        bus.flush   = 1'b0;
        #12;
        checkOutput("reset_busywait", bus.busywait, 1'b0);
        checkOutput("reset_mem_read", bus.mem_read, 1'b0);
        checkOutput("reset_mem_address", bus.mem_address, 0);
        checkOutput("reset_instruction", bus.instruction, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        model_clear();

        // Cold miss, spatial hit, then LRU eviction in set 4
        applyStimulus(32'h0000_0040);
        applyStimulus(32'h0000_0044);
        applyStimulus(32'h0000_00C0);
        applyStimulus(32'h0000_0040);
        applyStimulus(32'h0000_0140);
        applyStimulus(32'h0000_004C);
        applyStimulus(32'h0000_00C8);

        flushCache();
        applyStimulus(32'h0000_0040);

        // Flush pulse in the second cycle of a fill
        void'(model_access(32'h0000_0080));
        @(posedge clock); #1;
        bus.address = 32'h0000_0080;
        bus.read    = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        bus.flush = 1'b1;
        @(posedge clock); #1;
        bus.flush = 1'b0;
        n = 0;
        @(negedge clock);
        while (bus.busywait && n < 200) begin
            n++;
            @(negedge clock);
        end
        checkOutput("fill_before_flush", bus.busywait, 1'b0);
        checkOutput("fill_before_flush_instr", bus.instruction, mem_word(32'h80 >> 2));
        @(posedge clock); #1;
        bus.read = 1'b0;
        countFlush();
        applyStimulus(32'h0000_0080);

        // Reset in the third cycle of a fill abandons it and empties the cache
        applyStimulus(32'h0000_0040);
        @(posedge clock); #1;
        bus.address = 32'h0000_0100;
        bus.read    = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        checkOutput("pre_reset_mem_read", bus.mem_read, 1'b1);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_mem_read", bus.mem_read, 1'b0);
        checkOutput("async_busywait", bus.busywait, 1'b0);
        @(posedge clock); #1;
        bus.read = 1'b0;
        reset    = 1'b0;
        model_clear();
        applyStimulus(32'h0000_0040);

        for (int i = 0; i < 250; i++) begin
            int r = $urandom_range(0, 19);
            if (r == 0) begin
                flushCache();
            end else if (r == 1) begin
                idleCycle();
            end else begin
                mem_lat = $urandom_range(1, 6);
                a = (32'($urandom_range(0, 31)) << OFF_W)
                  | (32'($urandom_range(0, WORDS - 1)) << 2)
                  | 32'($urandom_range(0, 3))
                  | (32'($urandom_range(0, 1)) << 31);
                applyStimulus(a);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
